// File: rtl/alsu_driver.sv
// Command driver/checker for an ALSU: presents one command, waits LATENCY cycles, compares out.
// Optional halt-on-first-mismatch behaviour is enabled by defining ALSU_DRV_STOP_ON_ERR_EN.
`timescale 1ns/1ps

module alsu_driver #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_A,
  input  logic [2:0]       cmd_B,
  input  logic [2:0]       cmd_opcode,
  input  logic [6:0]       cmd_ctrl,
  input  logic [5:0]       cmd_exp,
  output logic [2:0]       A,
  output logic [2:0]       B,
  output logic [2:0]       opcode,
  output logic             cin,
  output logic             serial_in,
  output logic             direction,
  output logic             red_op_A,
  output logic             red_op_B,
  output logic             bypass_A,
  output logic             bypass_B,
  input  logic [5:0]       out,
  output logic             rsp_valid,
  output logic [5:0]       rsp_out,
  output logic             rsp_pass,
  output logic             error_flag,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned OUT_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
`ifdef ALSU_DRV_STOP_ON_ERR_EN
    CHECK = 2'd2,
    HALT  = 2'd3
`else
    CHECK = 2'd2
`endif
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [OUT_W-1:0]  exp_q;
  logic              accept;
  logic              match;

  // Ready is forced low while reset is held so it reads 0 during reset and 1 right after release.
  assign cmd_ready = rst & (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign match     = (out == exp_q);

  // Sequencer: accept -> count down LATENCY -> sample and score out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      exp_q      <= '0;
      A          <= '0;
      B          <= '0;
      opcode     <= '0;
      cin        <= 1'b0;
      serial_in  <= 1'b0;
      direction  <= 1'b0;
      red_op_A   <= 1'b0;
      red_op_B   <= 1'b0;
      bypass_A   <= 1'b0;
      bypass_B   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_out    <= '0;
      rsp_pass   <= 1'b0;
      error_flag <= 1'b0;
      pass_count <= '0;
      err_count  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            A        <= cmd_A;
            B        <= cmd_B;
            opcode   <= cmd_opcode;
            {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} <= cmd_ctrl;
            exp_q    <= cmd_exp;
            wait_cnt <= WAIT_W'(LATENCY);
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1)) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          rsp_out   <= out;
          rsp_pass  <= match;
          rsp_valid <= 1'b1;
          state     <= IDLE;
          if (match) begin
            if (pass_count != '1) begin
              pass_count <= pass_count + CNT_W'(1);
            end
          end else begin
            error_flag <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + CNT_W'(1);
            end
`ifdef ALSU_DRV_STOP_ON_ERR_EN
            state <= HALT;
`endif
          end
        end
`ifdef ALSU_DRV_STOP_ON_ERR_EN
        HALT: begin
          state <= HALT;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_driver.sv
// Directed bench for alsu_driver with a small pipelined ALSU stand-in driving out.
`timescale 1ns/1ps

module tb_alsu_driver;

  localparam int unsigned LAT = 2;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_A, cmd_B, cmd_opcode;
  logic [6:0]    cmd_ctrl;
  logic [5:0]    cmd_exp;
  logic [2:0]    A, B, opcode;
  logic          cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]    out;
  logic          rsp_valid;
  logic [5:0]    rsp_out;
  logic          rsp_pass;
  logic          error_flag;
  logic [CW-1:0] pass_count, err_count;
  logic [6:0]    ctrl_o;

  always #5 clk = ~clk;

  alsu_driver #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_opcode(cmd_opcode),
    .cmd_ctrl(cmd_ctrl), .cmd_exp(cmd_exp),
    .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out),
    .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_pass(rsp_pass),
    .error_flag(error_flag), .pass_count(pass_count), .err_count(err_count)
  );

  assign ctrl_o = {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};

  // ALSU stand-in: arithmetic/logic ops only, LAT register stages from inputs to out
  function automatic logic [5:0] alsu_f(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] op, input logic c);
    case (op)
      3'd0:    alsu_f = 6'(a & b);
      3'd1:    alsu_f = 6'(a ^ b);
      3'd2:    alsu_f = 6'(a) + 6'(b) + 6'(c);
      3'd3:    alsu_f = 6'(a) * 6'(b);
      default: alsu_f = 6'd0;
    endcase
  endfunction

  logic [5:0] pipe [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= alsu_f(A, B, opcode, cin);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign out = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] rsp_q [$];
  always @(negedge clk) if (rsp_valid) rsp_q.push_back({rsp_pass, rsp_out});

  int n_tests = 0;
  int n_fail  = 0;
  int e_pass  = 0;
  int e_err   = 0;
  logic e_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                       input logic [6:0] ctrl, input logic [5:0] exp, output int t_acc);
    int n;
    @(negedge clk);
    cmd_A = a; cmd_B = b; cmd_opcode = op; cmd_ctrl = ctrl; cmd_exp = exp;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
      t_acc = -1;
    end else begin
      @(posedge clk);
      #1;
      t_acc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic expect_rsp(input string name, input logic [5:0] exp_out, input logic exp_ok);
    int n;
    logic [6:0] r;
    n = 0;
    while (rsp_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rsp_seen"}, 32'(rsp_q.size() != 0), 1);
    r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 7'h7f;
    if (exp_ok) begin
      if (e_pass < 255) e_pass++;
    end else begin
      if (e_err < 255) e_err++;
      e_flag = 1'b1;
    end
    check({name, "_out"},   32'(r[5:0]), 32'(exp_out));
    check({name, "_pass"},  32'(r[6]), 32'(exp_ok));
    check({name, "_npass"}, 32'(pass_count), e_pass);
    check({name, "_nerr"},  32'(err_count), e_err);
    check({name, "_flag"},  32'(error_flag), 32'(e_flag));
  endtask

  task automatic run_cmd(input string name, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] op, input logic [6:0] ctrl, input logic [5:0] exp,
                         input logic [5:0] exp_out, input logic exp_ok);
    int t;
    issue(a, b, op, ctrl, exp, t);
    expect_rsp(name, exp_out, exp_ok);
    check({name, "_hold"}, 32'({A, B, opcode, ctrl_o}), 32'({a, b, op, ctrl}));
  endtask

  typedef struct {
    logic [2:0] a, b, op;
    logic [6:0] ctrl;
    logic [5:0] exp;
    logic [5:0] rout;
    logic       ok;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, hi;
    cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_opcode = '0; cmd_ctrl = '0; cmd_exp = '0;

    //        a     b     op    ctrl         exp    rout   ok
    vecs[0] = '{3'd6, 3'd5, 3'd1, 7'b0110000, 6'd3,  6'd3,  1'b1};
    vecs[1] = '{3'd6, 3'd3, 3'd2, 7'b1000000, 6'd10, 6'd10, 1'b1};
    vecs[2] = '{3'd7, 3'd7, 3'd3, 7'b0000000, 6'd49, 6'd49, 1'b1};
    vecs[3] = '{3'd5, 3'd6, 3'd0, 7'b0010000, 6'd4,  6'd4,  1'b1};
    vecs[4] = '{3'd7, 3'd7, 3'd2, 7'b0000000, 6'd14, 6'd14, 1'b1};
    vecs[5] = '{3'd3, 3'd3, 3'd1, 7'b0100000, 6'd0,  6'd0,  1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_outs", 32'({A, B, opcode, ctrl_o, rsp_valid, rsp_out, rsp_pass, error_flag}), 0);
    check("rst_counts", 32'({pass_count, err_count}), 0);
    rst = 1'b1;
    #1;
    check("ready_after_release", 32'(cmd_ready), 1);

    // Abort mid-WAIT
    issue(3'd7, 3'd3, 3'd0, 7'b1111111, 6'd3, t0);
    @(negedge clk);
    check("wait_not_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(cmd_ready), 0);
    check("abort_outs", 32'({A, B, opcode, ctrl_o, rsp_valid, rsp_out, rsp_pass, error_flag}), 0);
    check("abort_counts", 32'({pass_count, err_count}), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready_release", 32'(cmd_ready), 1);
    repeat (6) @(negedge clk);
    check("abort_no_rsp", rsp_q.size(), 0);
    check("abort_no_count", 32'({pass_count, err_count}), 0);

    // AND timing: strobe only after edge E0+3
    issue(3'd7, 3'd3, 3'd0, 7'b0000000, 6'd3, t0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("and_valid_e%0d", k), 32'(rsp_valid), 32'(k == 3));
      if (k == 3) begin
        check("and_rsp_out", 32'(rsp_out), 3);
        check("and_rsp_pass", 32'(rsp_pass), 1);
        check("and_ready_with_valid", 32'(cmd_ready), 1);
      end
    end
    expect_rsp("and", 6'd3, 1'b1);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ctrl,
              vecs[i].exp, vecs[i].rout, vecs[i].ok);
    end

    // Back-to-back with cmd_valid held high
    @(negedge clk);
    cmd_A = 3'd6; cmd_B = 3'd3; cmd_opcode = 3'd2; cmd_ctrl = 7'b1000000; cmd_exp = 6'd10;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_A = 3'd7; cmd_B = 3'd5; cmd_opcode = 3'd3; cmd_ctrl = 7'b0000000; cmd_exp = 6'd35;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
    @(posedge clk);
    #1;
    t1 = cyc;
    cmd_valid = 1'b0;
    check("b2b_spacing", 32'(t1 - t0), 4);
    expect_rsp("b2b_add", 6'd10, 1'b1);
    expect_rsp("b2b_mult", 6'd35, 1'b1);

    // Mismatch
    run_cmd("xor_bad", 3'd5, 3'd2, 3'd1, 7'b0000000, 6'd0, 6'd7, 1'b0);
`ifdef ALSU_DRV_STOP_ON_ERR_EN
    @(negedge clk);
    cmd_A = 3'd7; cmd_B = 3'd3; cmd_opcode = 3'd0; cmd_ctrl = '0; cmd_exp = 6'd3;
    cmd_valid = 1'b1;
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_ready) hi++;
    end
    cmd_valid = 1'b0;
    check("halt_ready_cycles", hi, 0);
    check("halt_rsp_hold", 32'(rsp_out), 7);
    check("halt_no_rsp", rsp_q.size(), 0);
`else
    hi = 0;
    run_cmd("after_err", 3'd7, 3'd3, 3'd0, 7'b0000000, 6'd3, 6'd3, 1'b1);
    check("flag_sticky", 32'(error_flag), 1);

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      run_cmd($sformatf("sat%0d", i), 3'd5, 3'd2, 3'd1, 7'b0000000, 6'd0, 6'd7, 1'b0);
    end
    check("err_saturated", 32'(err_count), 255);
    check("pass_unchanged", 32'(pass_count), 10);
`endif

    // Reset clears counters and sticky flag
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("final_rst_counts", 32'({pass_count, err_count}), 0);
    check("final_rst_flag", 32'(error_flag), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("final_ready", 32'(cmd_ready), 1);
    check("no_stray_rsp", rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
